// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU operation sequencer.
// The request record is the unit queued in the FIFO and latched into the ALU operand registers.
package alu_seq_pkg;
  localparam int A_W   = 3;
  localparam int B_W   = 3;
  localparam int OP_W  = 2;
  localparam int RES_W = 6;
  localparam int TAG_W = 2;
  localparam int LAT_W = 3;
  localparam int REQ_W = A_W + B_W + OP_W + TAG_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [A_W-1:0]  a;
    logic [B_W-1:0]  b;
    logic [OP_W-1:0] op;
    logic [TAG_W-1:0] tag;
  } req_t;
endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous request FIFO with a registered occupancy count; rst empties it.
// push is ignored when full and pop is ignored when empty.
module alu_seq_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_en, pop_en;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU requests, drives registered operands into an external combinational ALU,
// waits ALU_LAT settle cycles, and returns the captured result with its tag.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [A_W-1:0]   req_a,
  input  logic [B_W-1:0]   req_b,
  input  logic [OP_W-1:0]  req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [A_W-1:0]   alu_a,
  output logic [B_W-1:0]   alu_b,
  output logic [OP_W-1:0]  alu_sel,
  input  logic [RES_W-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [7:0]       done_count,
  output state_e           dbg_state
);
  // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready
  // are both high; a source holding valid keeps its payload stable until that edge.

  req_t             fifo_din, fifo_dout;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  req_t             op_q, op_d;
  logic [RES_W-1:0] rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       done_count_q, done_count_d;

  assign fifo_din  = '{a: req_a, b: req_b, op: req_op, tag: req_tag};
  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && !fifo_full;

  alu_seq_fifo #(
    .WIDTH(REQ_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    op_d         = op_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_valid_d  = rsp_valid_q;
    done_count_d = done_count_q;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          op_d      = fifo_dout;
          lat_cnt_d = '0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (lat_cnt_q != LAT_W'(ALU_LAT)) begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end else begin
          rsp_result_d = alu_result;
          rsp_tag_d    = op_q.tag;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        // Chain straight into the next queued op so the ALU sees no idle bubble.
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          done_count_d = done_count_q + 8'd1;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            op_d      = fifo_dout;
            lat_cnt_d = '0;
            state_d   = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      op_q         <= '0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_valid_q  <= 1'b0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      op_q         <= op_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_valid_q  <= rsp_valid_d;
      done_count_q <= done_count_d;
    end
  end

  assign alu_a      = op_q.a;
  assign alu_b      = op_q.b;
  assign alu_sel    = op_q.op;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_valid  = rsp_valid_q;
  assign done_count = done_count_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: one instance with ALU_LAT=0 and one with ALU_LAT=2 share the stimulus.
// Each instance is fed by a reference ALU (00 add, 01 sub, 10 and, 11 or).
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             req_valid = 1'b0;
  logic             rsp_ready = 1'b0;
  logic [A_W-1:0]   req_a = '0;
  logic [B_W-1:0]   req_b = '0;
  logic [OP_W-1:0]  req_op = '0;
  logic [TAG_W-1:0] req_tag = '0;

  logic             r0_req_ready, r0_rsp_valid, r0_busy;
  logic [A_W-1:0]   r0_alu_a;
  logic [B_W-1:0]   r0_alu_b;
  logic [OP_W-1:0]  r0_alu_sel;
  logic [RES_W-1:0] r0_alu_result, r0_rsp_result;
  logic [TAG_W-1:0] r0_rsp_tag;
  logic [7:0]       r0_done_count;
  state_e           r0_dbg_state;

  logic             r2_req_ready, r2_rsp_valid, r2_busy;
  logic [A_W-1:0]   r2_alu_a;
  logic [B_W-1:0]   r2_alu_b;
  logic [OP_W-1:0]  r2_alu_sel;
  logic [RES_W-1:0] r2_alu_result, r2_rsp_result;
  logic [TAG_W-1:0] r2_rsp_tag;
  logic [7:0]       r2_done_count;
  state_e           r2_dbg_state;

  function automatic logic [RES_W-1:0] alu_ref(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                               input logic [OP_W-1:0] op);
    case (op)
      2'b00:   return {3'b000, a} + {3'b000, b};
      2'b01:   return {3'b000, a} - {3'b000, b};
      2'b10:   return {3'b000, a & b};
      default: return {3'b000, a | b};
    endcase
  endfunction

  assign r0_alu_result = alu_ref(r0_alu_a, r0_alu_b, r0_alu_sel);
  assign r2_alu_result = alu_ref(r2_alu_a, r2_alu_b, r2_alu_sel);

  alu_op_sequencer #(.DEPTH(4), .ALU_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r0_req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .alu_a(r0_alu_a), .alu_b(r0_alu_b), .alu_sel(r0_alu_sel), .alu_result(r0_alu_result),
    .rsp_valid(r0_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(r0_rsp_result),
    .rsp_tag(r0_rsp_tag), .busy(r0_busy), .done_count(r0_done_count), .dbg_state(r0_dbg_state)
  );

  alu_op_sequencer #(.DEPTH(4), .ALU_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r2_req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .alu_a(r2_alu_a), .alu_b(r2_alu_b), .alu_sel(r2_alu_sel), .alu_result(r2_alu_result),
    .rsp_valid(r2_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(r2_rsp_result),
    .rsp_tag(r2_rsp_tag), .busy(r2_busy), .done_count(r2_done_count), .dbg_state(r2_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rsp_cyc = -1;
  bit track_gap = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sampled at the negedge: records dut0 handshakes that the coming posedge completes.
  task automatic tick();
    logic [7:0] e;
    if (req_valid && r0_req_ready) exp_q.push_back({req_tag, alu_ref(req_a, req_b, req_op)});
    if (r0_rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_rsp_tag_result", {r0_rsp_tag, r0_rsp_result}, e);
      end
      if (track_gap && last_rsp_cyc >= 0) check("rsp_gap", cyc - last_rsp_cyc, 2);
      last_rsp_cyc = cyc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drive_req(input int a, input int b, input int op, input int tag);
    req_valid = 1'b1;
    req_a     = A_W'(a);
    req_b     = B_W'(b);
    req_op    = OP_W'(op);
    req_tag   = TAG_W'(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int seen;
    int sent;
    int guard;
    bit acc;

    // Reset state
    do_reset(2);
    check("rst_req_ready", r0_req_ready, 1);
    check("rst_rsp_valid", r0_rsp_valid, 0);
    check("rst_alu_a", r0_alu_a, 0);
    check("rst_alu_b", r0_alu_b, 0);
    check("rst_alu_sel", r0_alu_sel, 0);
    check("rst_busy", r0_busy, 0);
    check("rst_done", r0_done_count, 0);
    check("rst_rsp_result", r0_rsp_result, 0);
    check("rst_rsp_tag", r0_rsp_tag, 0);
    check("rst2_req_ready", r2_req_ready, 1);
    check("rst2_busy", r2_busy, 0);

    // Single op, ALU_LAT=0: handshake at edge N, response after N+2
    rsp_ready = 1'b1;
    drive_req(3, 5, 0, 1);
    tick();
    req_valid = 1'b0;
    check("lat0_n0_valid", r0_rsp_valid, 0);
    check("lat0_n0_busy", r0_busy, 1);
    tick();
    check("lat0_n1_valid", r0_rsp_valid, 0);
    check("lat0_n1_alu_a", r0_alu_a, 3);
    check("lat0_n1_alu_b", r0_alu_b, 5);
    check("lat0_n1_alu_sel", r0_alu_sel, 0);
    check("lat0_n1_state", r0_dbg_state, EXEC);
    tick();
    check("lat0_n2_valid", r0_rsp_valid, 1);
    check("lat0_n2_result", r0_rsp_result, 8);
    check("lat0_n2_tag", r0_rsp_tag, 1);
    tick();
    check("lat0_done", r0_done_count, 1);
    check("lat0_valid_drop", r0_rsp_valid, 0);
    check("lat0_idle_busy", r0_busy, 0);

    // Backpressure: offer tags 0..5 with rsp_ready low
    rsp_ready = 1'b0;
    accepted  = 0;
    for (int t = 0; t < 6; t++) begin
      drive_req(t, 1, 0, t % 4);
      if (r0_req_ready) accepted++;
      tick();
    end
    req_valid = 1'b0;
    check("bp_accepted", accepted, 5);
    check("bp_req_ready", r0_req_ready, 0);
    check("bp_rsp_valid", r0_rsp_valid, 1);
    check("bp_rsp_tag", r0_rsp_tag, 0);
    check("bp_rsp_result", r0_rsp_result, 1);
    check("bp_state", r0_dbg_state, RESP);
    repeat (3) tick();
    check("bp_hold_result", r0_rsp_result, 1);
    check("bp_hold_valid", r0_rsp_valid, 1);
    rsp_ready    = 1'b1;
    track_gap    = 1'b1;
    last_rsp_cyc = -1;
    guard        = 0;
    while ((exp_q.size() != 0 || r0_rsp_valid) && guard < 40) begin
      tick();
      guard++;
    end
    track_gap = 1'b0;
    check("bp_drain_timeout", guard < 40, 1);
    check("bp_drain_done", r0_done_count, 6);
    check("bp_ready_again", r0_req_ready, 1);

    // ALU_LAT=2: sub 7-2, response after N+4, operands stable meanwhile
    do_reset(1);
    rsp_ready = 1'b1;
    drive_req(7, 2, 1, 2);
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("lat2_alu_a", r2_alu_a, 7);
      check("lat2_alu_b", r2_alu_b, 2);
      check("lat2_alu_sel", r2_alu_sel, 1);
      check("lat2_valid_timing", r2_rsp_valid, k == 4);
    end
    check("lat2_result", r2_rsp_result, 5);
    check("lat2_tag", r2_rsp_tag, 2);
    tick();
    check("lat2_done", r2_done_count, 1);
    check("lat2_hold_alu_a", r2_alu_a, 7);

    // Reset mid-EXEC with ops queued
    do_reset(1);
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      drive_req(t + 1, t, 2, t);
      tick();
    end
    req_valid = 1'b0;
    check("mid_state_exec", r2_dbg_state, EXEC);
    check("mid_busy", r2_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", r2_rsp_valid, 0);
    check("mid_rst_busy", r2_busy, 0);
    check("mid_rst_state", r2_dbg_state, IDLE);
    check("mid_rst_alu_a", r2_alu_a, 0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (r2_rsp_valid || r0_rsp_valid) seen++;
      tick();
    end
    check("mid_no_rsp", seen, 0);
    check("mid_done", r2_done_count, 0);

    // 256 back-to-back completions wrap done_count
    do_reset(1);
    rsp_ready = 1'b1;
    sent      = 0;
    guard     = 0;
    while ((sent < 256 || exp_q.size() != 0) && guard < 2000) begin
      if (sent < 256) drive_req(sent % 8, (sent / 8) % 8, sent % 4, sent % 4);
      else req_valid = 1'b0;
      acc = req_valid && r0_req_ready;
      tick();
      if (acc) sent++;
      guard++;
    end
    req_valid = 1'b0;
    check("wrap_timeout", guard < 2000, 1);
    check("wrap_done_zero", r0_done_count, 0);
    drive_req(1, 6, 3, 3);
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    check("wrap_done_one", r0_done_count, 1);
    check("wrap_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
